// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter. The first byte into an idle, empty queue strobes 3 cycles after its push.
// Backpressure: push_i is rejected with a drop_o pulse while full, unless a pop happens in the same cycle.
module uart_tx_queue #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic [7:0]                 data_i,
  input  logic                       push_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_o,
  output logic                       busy_o,
  output logic [7:0]                 txdata_o,
  output logic                       txclk_o,
  input  logic                       txready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(ACK_TIMEOUT+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_RDY
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [7:0]     txdata_q, txdata_d;
  logic           txclk_q, txclk_d;
  logic           drop_q, drop_d;
  logic           pop;
  logic           accept;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign drop_o   = drop_q;
  assign busy_o   = (state_q != S_IDLE);
  assign txdata_o = txdata_q;
  assign txclk_o  = txclk_q;

  // A full queue still accepts a byte in the cycle the FSM pops its head.
  assign accept = push_i && (!full_o || pop);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    txdata_d = txdata_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_o && txready_i) begin
          state_d  = S_LOAD;
          txdata_d = mem_q[rd_ptr_q];
        end
      end
      S_LOAD: begin
        pop     = 1'b1;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        state_d = S_WAIT_BUSY;
        timer_d = '0;
      end
      S_WAIT_BUSY: begin
        if (!txready_i) begin
          state_d = S_WAIT_RDY;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_RDY: begin
        if (txready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    txclk_d = (state_d == S_STROBE);
  end

  always_comb begin
    rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    drop_d   = push_i && !accept;
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      txdata_q <= 8'h00;
      txclk_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: accepted pushes queue expected bytes, every txclk_o strobe pops one and compares.
module tb_uart_tx_queue;

  localparam int DEPTH = 4;
  localparam int ACK_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       push_i = 1'b0;
  logic       full_o, empty_o, drop_o, busy_o, txclk_o;
  logic [2:0] count_o;
  logic [7:0] txdata_o;
  logic       txready_i;
  logic       man_rdy = 1'b1;
  logic       auto_rdy = 1'b1;
  logic       uart_auto = 1'b0;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int model_cnt = 0;
  logic [7:0] sb [$];

  assign txready_i = uart_auto ? auto_rdy : man_rdy;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_i(rst_i), .data_i(data_i), .push_i(push_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .drop_o(drop_o),
    .busy_o(busy_o), .txdata_o(txdata_o), .txclk_o(txclk_o), .txready_i(txready_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i && txclk_o) begin
      strobes++;
      if (sb.size() == 0) begin
        chk("strobe_unexpected", 32'(txclk_o), 32'd0);
      end else begin
        chk("strobe_data", 32'(txdata_o), 32'(sb.pop_front()));
      end
    end
  end

  // UART model: ready drops 2 cycles after each strobe and stays low for 5 cycles.
  initial forever begin
    @(negedge clk);
    if (uart_auto && txclk_o) begin
      repeat (2) @(posedge clk);
      #1 auto_rdy = 1'b0;
      repeat (5) @(posedge clk);
      #1 auto_rdy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    push_i = 1'b0;
    sb.delete();
    model_cnt = 0;
    repeat (2) tick();
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_txclk", 32'(txclk_o), 32'd0);
    chk("rst_txdata", 32'(txdata_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
    rst_i = 1'b0;
  endtask

  // Drive one push for this cycle; the bench model decides acceptance.
  task automatic push_byte(input logic [7:0] b, input logic pop_now);
    data_i = b;
    push_i = 1'b1;
    if (model_cnt < DEPTH || pop_now) begin
      sb.push_back(b);
      if (!pop_now) model_cnt++;
    end
  endtask

  task automatic note_pop();
    if (model_cnt > 0) model_cnt--;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(empty_o && !busy_o && sb.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
    model_cnt = 0;
  endtask

  initial begin
    int s0;
    bit prev_busy;
    int n;
    do_reset();

    // 1: single byte latency
    man_rdy = 1'b1;
    push_byte(8'h41, 1'b0);
    tick();
    push_i = 1'b0;
    chk("t1_count_c1", 32'(count_o), 32'd1);
    chk("t1_empty_c1", 32'(empty_o), 32'd0);
    chk("t1_busy_c1", 32'(busy_o), 32'd0);
    tick();
    chk("t1_busy_c2", 32'(busy_o), 32'd1);
    chk("t1_txdata_c2", 32'(txdata_o), 32'h41);
    chk("t1_txclk_c2", 32'(txclk_o), 32'd0);
    tick();
    chk("t1_txclk_c3", 32'(txclk_o), 32'd1);
    tick();
    chk("t1_txclk_c4", 32'(txclk_o), 32'd0);
    chk("t1_count_c4", 32'(count_o), 32'd0);
    repeat (ACK_TIMEOUT - 1) tick();
    chk("t1_busy_c11", 32'(busy_o), 32'd1);
    tick();
    chk("t1_busy_c12", 32'(busy_o), 32'd0);
    model_cnt = 0;

    // 2: back-to-back with a UART that goes busy after each strobe
    uart_auto = 1'b1;
    s0 = strobes;
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i), 1'b0);
      tick();
    end
    push_i = 1'b0;
    wait_drain("t2_drain_timeout", 200);
    chk("t2_strobes", 32'(strobes - s0), 32'd4);
    uart_auto = 1'b0;

    // 3: overflow while UART is not ready
    man_rdy = 1'b0;
    s0 = strobes;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'hA0 + 8'(i), 1'b0);
      tick();
      if (i == 3) chk("t3_full_after4", 32'(full_o), 32'd1);
    end
    push_i = 1'b0;
    chk("t3_drop_pulse", 32'(drop_o), 32'd1);
    chk("t3_count", 32'(count_o), 32'd4);
    tick();
    chk("t3_drop_clear", 32'(drop_o), 32'd0);
    chk("t3_no_strobe", 32'(strobes - s0), 32'd0);
    man_rdy = 1'b1;
    wait_drain("t3_drain_timeout", 200);
    chk("t3_strobes", 32'(strobes - s0), 32'd4);

    // 4: push into a full FIFO during LOAD, 12 bytes total with wrap-around
    man_rdy = 1'b0;
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'h10 + 8'(i), 1'b0);
      tick();
    end
    push_i = 1'b0;
    man_rdy = 1'b1;
    prev_busy = busy_o;
    for (int k = 4; k < 12; k++) begin
      n = 0;
      while (!(busy_o && !prev_busy) && n < 100) begin
        prev_busy = busy_o;
        tick();
        n++;
      end
      chk("t4_load_timeout", 32'(n < 100), 32'd1);
      chk("t4_full_at_load", 32'(full_o), 32'd1);
      push_byte(8'h10 + 8'(k), 1'b1);
      note_pop();
      model_cnt++;
      prev_busy = busy_o;
      tick();
      push_i = 1'b0;
      chk("t4_no_drop", 32'(drop_o), 32'd0);
      chk("t4_count_held", 32'(count_o), 32'd4);
      prev_busy = busy_o;
    end
    wait_drain("t4_drain_timeout", 400);
    chk("t4_strobes", 32'(strobes - s0), 32'd12);

    // 6: not ready from reset, byte held until ready rises
    man_rdy = 1'b0;
    do_reset();
    s0 = strobes;
    push_byte(8'hFF, 1'b0);
    tick();
    push_i = 1'b0;
    repeat (50) tick();
    chk("t6_no_strobe", 32'(strobes - s0), 32'd0);
    chk("t6_busy_idle", 32'(busy_o), 32'd0);
    man_rdy = 1'b1;
    wait_drain("t6_drain_timeout", 100);
    chk("t6_one_strobe", 32'(strobes - s0), 32'd1);

    // 5: asynchronous reset in the middle of STROBE
    push_byte(8'h5A, 1'b0);
    tick();
    push_byte(8'h5B, 1'b0);
    tick();
    push_i = 1'b0;
    n = 0;
    while (!txclk_o && n < 20) begin
      tick();
      n++;
    end
    chk("t5_strobe_timeout", 32'(txclk_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_txclk", 32'(txclk_o), 32'd0);
    chk("t5_txdata", 32'(txdata_o), 32'd0);
    chk("t5_count", 32'(count_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    sb.delete();
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
